tqv_spi_reg_host: RTL and testbench



---
 rtl/tqv_spi_reg_host.sv | 88 ++++++++
 tb/tb_tqv_spi_reg_host.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_spi_reg_host.sv
// tqv_spi_reg_host: SPI mode-0 host that serialises one 48-bit register frame per command
// and returns the last 32 MISO bits on a single-cycle response strobe.
module tqv_spi_reg_host #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [1:0]        cmd_width,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  bits;
  logic [46:0] sh;
  logic [31:0] rx;
  logic        rw_q;
  logic        last;
  logic        rsp_set;
  logic [47:0] frame;
  assign last = cnt == 8'(CLK_DIV - 1);
  assign frame = {cmd_rw, cmd_width == 2'd3 ? 2'd2 : cmd_width, 13'(cmd_addr), cmd_rw ? cmd_wdata : 32'd0};
  // the strobe is registered, so it is raised on the edge that enters the final GAP cycle
  assign rsp_set = CLK_DIV == 1 ? state == HOLD && last : state == GAP && cnt == 8'(CLK_DIV - 2);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bits      <= '0;
      sh        <= '0;
      rx        <= '0;
      rw_q      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= rsp_set;
      if (rsp_set) rsp_rdata <= rw_q ? 32'd0 : rx;
      cnt <= last || state == IDLE ? 8'd0 : cnt + 8'd1;
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          state     <= SETUP;
          cmd_ready <= 1'b0;
          spi_cs_n  <= 1'b0;
          spi_mosi  <= frame[47];
          sh        <= frame[46:0];
          rw_q      <= cmd_rw;
          bits      <= '0;
        end
        SETUP: if (last) state <= SHIFT;
        SHIFT: if (last) begin
          spi_sclk <= !spi_sclk;
          if (!spi_sclk) rx <= {rx[30:0], spi_miso};
          else if (bits == 6'd47) state <= HOLD;
          else begin
            bits     <= bits + 6'd1;
            sh       <= {sh[45:0], 1'b0};
            spi_mosi <= sh[46];
          end
        end
        HOLD: if (last) begin
          state    <= GAP;
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
        end
        GAP: if (last) begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tqv_spi_reg_host.sv
// tb_tqv_spi_reg_host: randomized frame-level checks of two hosts (CLK_DIV 4 and 1)
// against a reference model built from the frame layout and phase lengths.
module tb_tqv_spi_reg_host;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  valid = '0;
  logic [1:0]  rw = '0;
  logic [1:0]  ready, rsp, cs_n, sclk, mosi;
  logic [1:0]  width [2];
  logic [5:0]  addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIV = g == 0 ? 4 : 1;
    logic        sdi = 1'b0;
    logic [47:0] slv_load = '0;
    logic [47:0] cap = '0;
    logic [47:0] frames [$];
    int          counts [$];
    int          pulses = 0, bad = 0, idx = 0, rsps = 0, overlap = 0;
    longint      last_rise = 0;
    logic        pcs = 1'b1, psclk = 1'b0;
    tqv_spi_reg_host #(.CLK_DIV(DIV), .ADDR_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(valid[g]), .cmd_ready(ready[g]),
      .cmd_rw(rw[g]), .cmd_width(width[g]), .cmd_addr(addr[g]), .cmd_wdata(wdata[g]),
      .rsp_valid(rsp[g]), .rsp_rdata(rdata[g]), .spi_cs_n(cs_n[g]), .spi_sclk(sclk[g]),
      .spi_mosi(mosi[g]), .spi_miso(sdi)
    );
    // slave: presents slv_load MSB first, advancing on each SCLK fall; also records MOSI per rise
    always @(cs_n[g] or sclk[g]) begin
      if (cs_n[g] !== pcs && cs_n[g] === 1'b0) begin
        cap = '0;
        pulses = 0;
        idx = 0;
      end
      if (cs_n[g] !== pcs && cs_n[g] === 1'b1) begin
        frames.push_back(cap);
        counts.push_back(pulses);
      end
      if (sclk[g] !== psclk && sclk[g] === 1'b1) begin
        cap = {cap[46:0], mosi[g]};
        if (pulses > 0 && longint'($time) - last_rise != longint'(20 * DIV)) bad++;
        last_rise = longint'($time);
        pulses++;
      end
      if (sclk[g] !== psclk && sclk[g] === 1'b0 && cs_n[g] === 1'b0) idx++;
      sdi = idx < 48 ? slv_load[47 - idx] : 1'b0;
      pcs = cs_n[g];
      psclk = sclk[g];
    end
    always @(negedge clk) begin
      if (rsp[g] === 1'b1) rsps++;
      if (rsp[g] === 1'b1 && ready[g] === 1'b1) overlap++;
    end
  end

  function automatic logic [47:0] model_frame(input logic r, input logic [1:0] w, input logic [5:0] a, input logic [31:0] d);
    return {r, w == 2'd3 ? 2'd2 : w, 7'd0, a, r ? d : 32'd0};
  endfunction

  // lat counts the offering cycle as 1 through the rsp_valid cycle inclusive
  task automatic xfer(input logic r, input logic [1:0] w, input logic [5:0] a, input logic [31:0] d,
                      input logic [47:0] s, input int poke, output int lat, output int csl, output logic busy_ready);
    u[0].slv_load = s;
    u[0].frames.delete();
    u[0].counts.delete();
    rw[0] = r; width[0] = w; addr[0] = a; wdata[0] = d; valid[0] = 1'b1;
    lat = 1; csl = 0; busy_ready = 1'bx;
    while (lat <= 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 2) valid[0] = 1'b0;
      if (poke > 0 && lat == poke) begin
        busy_ready = ready[0];
        valid[0] = 1'b1; addr[0] = ~a; wdata[0] = ~d; rw[0] = ~r; width[0] = ~w;
      end
      if (poke > 0 && lat == poke + 1) valid[0] = 1'b0;
      if (cs_n[0] === 1'b0) csl++;
      if (rsp[0] === 1'b1) break;
    end
    @(negedge clk);
  endtask

  task automatic test_xfer(input string nm, input logic r, input logic [1:0] w, input logic [5:0] a,
                           input logic [31:0] d, input logic [47:0] s, input int poke);
    int lat, csl, r0, pc;
    logic br;
    logic [47:0] exp, fr;
    logic [31:0] erd;
    exp = model_frame(r, w, a, d);
    erd = r ? 32'd0 : s[31:0];
    r0 = u[0].rsps;
    xfer(r, w, a, d, s, poke, lat, csl, br);
    fr = u[0].frames.size() > 0 ? u[0].frames[0] : 'x;
    pc = u[0].counts.size() > 0 ? u[0].counts[0] : -1;
    vectors++; if (lat !== 1 + 4 * 99) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, 1 + 4 * 99); end
    vectors++; if (csl !== 98 * 4) begin errors++; $display("FAIL %s cs_low_cycles: got %0d want %0d", nm, csl, 98 * 4); end
    vectors++; if (u[0].frames.size() !== 1) begin errors++; $display("FAIL %s frame_count: got %0d want 1", nm, u[0].frames.size()); end
    vectors++; if (fr !== exp) begin errors++; $display("FAIL %s mosi_frame: got %h want %h", nm, fr, exp); end
    vectors++; if (pc !== 48) begin errors++; $display("FAIL %s sclk_pulses: got %0d want 48", nm, pc); end
    vectors++; if (u[0].bad !== 0) begin errors++; $display("FAIL %s sclk_period: %0d bad periods, want 0", nm, u[0].bad); end
    vectors++; if (rdata[0] !== erd) begin errors++; $display("FAIL %s rsp_rdata: got %h want %h", nm, rdata[0], erd); end
    vectors++; if (rsp[0] !== 1'b0) begin errors++; $display("FAIL %s rsp_width: got %b want 0", nm, rsp[0]); end
    vectors++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL %s ready_after: got %b want 1", nm, ready[0]); end
    vectors++; if (u[0].rsps - r0 !== 1) begin errors++; $display("FAIL %s rsp_count: got %0d want 1", nm, u[0].rsps - r0); end
    if (poke > 0) begin
      vectors++; if (br !== 1'b0) begin errors++; $display("FAIL %s busy_ready: got %b want 0", nm, br); end
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      width[g] = '0; addr[g] = '0; wdata[g] = '0;
    end
    repeat (3) @(negedge clk);
    vectors++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b want 1", ready[0]); end
    vectors++; if (rsp[0] !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b want 0", rsp[0]); end
    vectors++; if (rdata[0] !== 32'd0) begin errors++; $display("FAIL reset rsp_rdata: got %h want 0", rdata[0]); end
    vectors++; if (cs_n !== 2'b11) begin errors++; $display("FAIL reset cs_n: got %b want 11", cs_n); end
    vectors++; if (sclk !== 2'b00) begin errors++; $display("FAIL reset sclk: got %b want 00", sclk); end
    vectors++; if (mosi !== 2'b00) begin errors++; $display("FAIL reset mosi: got %b want 00", mosi); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (ready !== 2'b11) begin errors++; $display("FAIL reset ready_after_release: got %b want 11", ready); end
  endtask

  task automatic test_write();
    test_xfer("write", 1'b1, 2'd2, 6'h05, 32'hDEADBEEF, {$urandom, $urandom} >> 16, 0);
    vectors++; if (u[0].frames[0] !== 48'hC005_DEADBEEF) begin errors++; $display("FAIL write literal_frame: got %h want c005deadbeef", u[0].frames[0]); end
  endtask

  task automatic test_read();
    logic [47:0] s;
    s = {16'($urandom), 32'h12345678};
    test_xfer("read", 1'b0, 2'd0, 6'h3F, $urandom, s, 0);
    vectors++; if (u[0].frames[0] !== 48'h003F_00000000) begin errors++; $display("FAIL read literal_frame: got %h want 003f00000000", u[0].frames[0]); end
    vectors++; if (rdata[0] !== 32'h12345678) begin errors++; $display("FAIL read literal_rdata: got %h want 12345678", rdata[0]); end
  endtask

  task automatic test_busy_ignore();
    int r0;
    test_xfer("busy", 1'($urandom), 2'($urandom), 6'($urandom), $urandom, {$urandom, $urandom} >> 16, 20);
    r0 = u[0].rsps;
    repeat (10) @(negedge clk);
    vectors++; if (cs_n[0] !== 1'b1 || u[0].rsps !== r0) begin errors++; $display("FAIL busy no_second_frame: cs_n=%b extra_rsp=%0d want 1/0", cs_n[0], u[0].rsps - r0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      test_xfer($sformatf("random%0d", i), 1'($urandom), 2'($urandom), 6'($urandom), $urandom, {$urandom, $urandom} >> 16, 0);
  endtask

  task automatic test_width3();
    test_xfer("width3", 1'b1, 2'd3, 6'($urandom), $urandom, '0, 0);
    vectors++; if (u[0].frames[0][46:45] !== 2'b10) begin errors++; $display("FAIL width3 header: got %b want 10", u[0].frames[0][46:45]); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] a1, a2;
    logic [31:0] d1, d2, rd1;
    logic [47:0] s;
    int cyc, acc, hi;
    int rt [$];
    bit pend;
    a1 = 6'($urandom); a2 = 6'($urandom); d1 = $urandom; d2 = $urandom;
    s = {$urandom, $urandom} >> 16;
    u[1].slv_load = s;
    u[1].frames.delete();
    u[1].counts.delete();
    rw[1] = 1'b0; width[1] = 2'd2; addr[1] = a1; wdata[1] = d1; valid[1] = 1'b1;
    cyc = 0; acc = 0; hi = 0; pend = 0; rd1 = 'x;
    while (rt.size() < 2 && cyc < 1000) begin
      if (ready[1] === 1'b1 && valid[1] === 1'b1) begin acc++; pend = 1; end
      if (rsp[1] === 1'b1) begin rt.push_back(cyc); if (rt.size() == 1) rd1 = rdata[1]; end
      if (u[1].frames.size() == 1 && cs_n[1] === 1'b1) hi++;
      @(negedge clk);
      cyc++;
      if (pend) begin
        pend = 0;
        if (acc == 1) begin rw[1] = 1'b1; addr[1] = a2; wdata[1] = d2; end
        else valid[1] = 1'b0;
      end
    end
    valid[1] = 1'b0;
    vectors++; if (rt.size() !== 2) begin errors++; $display("FAIL b2b rsp_count: got %0d want 2", rt.size()); end
    vectors++; if (rt.size() == 2 && rt[1] - rt[0] !== 1 + 1 * 99) begin errors++; $display("FAIL b2b rsp_spacing: got %0d want 100", rt[1] - rt[0]); end
    vectors++; if (hi !== 2) begin errors++; $display("FAIL b2b cs_high_gap: got %0d want 2", hi); end
    vectors++; if (u[1].frames.size() !== 2) begin errors++; $display("FAIL b2b frame_count: got %0d want 2", u[1].frames.size()); end
    vectors++; if (u[1].frames.size() > 0 && u[1].frames[0] !== model_frame(1'b0, 2'd2, a1, d1)) begin errors++; $display("FAIL b2b frame1: got %h want %h", u[1].frames[0], model_frame(1'b0, 2'd2, a1, d1)); end
    vectors++; if (u[1].frames.size() > 1 && u[1].frames[1] !== model_frame(1'b1, 2'd2, a2, d2)) begin errors++; $display("FAIL b2b frame2: got %h want %h", u[1].frames[1], model_frame(1'b1, 2'd2, a2, d2)); end
    vectors++; if (u[1].counts.size() > 1 && (u[1].counts[0] !== 48 || u[1].counts[1] !== 48)) begin errors++; $display("FAIL b2b sclk_pulses: got %0d/%0d want 48/48", u[1].counts[0], u[1].counts[1]); end
    vectors++; if (u[1].bad !== 0) begin errors++; $display("FAIL b2b sclk_period: %0d bad periods, want 0", u[1].bad); end
    vectors++; if (rd1 !== s[31:0]) begin errors++; $display("FAIL b2b read_rdata: got %h want %h", rd1, s[31:0]); end
    vectors++; if (rdata[1] !== 32'd0) begin errors++; $display("FAIL b2b write_rdata: got %h want 0", rdata[1]); end
  endtask

  task automatic test_reset_mid();
    int n, r0, lows;
    u[0].slv_load = {$urandom, $urandom} >> 16;
    rw[0] = 1'b1; width[0] = 2'd2; addr[0] = 6'($urandom); wdata[0] = $urandom; valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    n = 0;
    while (u[0].pulses < 20 && n < 2000) begin @(negedge clk); n++; end
    vectors++; if (sclk[0] !== 1'b1) begin errors++; $display("FAIL rstmid sclk_before: got %b want 1", sclk[0]); end
    r0 = u[0].rsps;
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0) begin errors++; $display("FAIL rstmid async_outputs: cs_n=%b sclk=%b want 1/0", cs_n[0], sclk[0]); end
    vectors++; if (ready[0] !== 1'b1 || rsp[0] !== 1'b0 || mosi[0] !== 1'b0) begin errors++; $display("FAIL rstmid ready_rsp_mosi: got %b%b%b want 100", ready[0], rsp[0], mosi[0]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (450) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b1) lows++;
    end
    vectors++; if (u[0].rsps !== r0 || lows !== 0) begin errors++; $display("FAIL rstmid dropped: rsp=%0d cs_low=%0d want 0/0", u[0].rsps - r0, lows); end
    vectors++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL rstmid ready_after: got %b want 1", ready[0]); end
    test_xfer("after_reset", 1'b1, 2'($urandom), 6'($urandom), $urandom, {$urandom, $urandom} >> 16, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_random();
    test_width3();
    test_back_to_back();
    test_reset_mid();
    vectors++; if (u[0].overlap !== 0 || u[1].overlap !== 0) begin errors++; $display("FAIL rsp_ready_overlap: got %0d/%0d want 0/0", u[0].overlap, u[1].overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
